// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    // Fixed in this revision; the counter and lane logic assume 4 bytes.
    localparam int unsigned BYTES_PER_INSTR = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Final counter value in FETCH: the cycle that captures the last byte.
    localparam logic [2:0] LAST_CNT = 3'(BYTES_PER_INSTR);

    // Sequential PC increment after an accepted instruction.
    localparam logic [31:0] PC_STEP = 32'(BYTES_PER_INSTR);

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, program memory, branch logic and decoder.
interface instr_fetch_unit_if;

    logic        enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;

    // Fetch unit side.
    modport master (
        input  enable,
        input  mem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  instr_ready,
        output mem_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        output busy
    );

    // Environment side: memory, branch unit and decoder.
    modport slave (
        output enable,
        output mem_data,
        output redirect_valid,
        output redirect_pc,
        output instr_ready,
        input  mem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  busy
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: walks four byte addresses through a memory with
// one cycle of read latency, assembles a little-endian word and hands it to the
// decoder over valid/ready. Owns the PC and honours redirects at any time.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0][7:0] lanes_q;
    logic [1:0]      lane_idx;
    logic [31:0]     addr_off;
    logic            accept;

    // Only the low byte of the memory word carries data.
    logic unused_mem_bits;
    assign unused_mem_bits = ^bus.mem_data[31:8];

    assign accept   = (state_q == FETCH_VALID) && bus.instr_ready;
    // Data arriving in cycle c belongs to the address issued in cycle c-1.
    assign lane_idx = 2'(cnt_q - 3'd1);

    // State, PC and byte counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte-lane capture; a redirect throws away any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.redirect_valid) begin
            lanes_q <= '0;
        end else if (state_q == FETCH_BUSY && cnt_q != 3'd0) begin
            lanes_q[lane_idx] <= bus.mem_data[7:0];
        end
    end

    // Next-state logic; redirect overrides everything, including an accept.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            cnt_d   = 3'd0;
            state_d = bus.enable ? FETCH_BUSY : FETCH_IDLE;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (bus.enable) begin
                        state_d = FETCH_BUSY;
                        cnt_d   = 3'd0;
                    end
                end
                FETCH_BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = FETCH_VALID;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                FETCH_VALID: begin
                    if (accept) begin
                        pc_d    = pc_q + PC_STEP;
                        cnt_d   = 3'd0;
                        state_d = bus.enable ? FETCH_BUSY : FETCH_IDLE;
                    end
                end
                default: begin
                    state_d = FETCH_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Memory address: pc+cnt while issuing, parked on the last byte while it returns.
    always_comb begin
        addr_off = 32'd0;
        if (state_q == FETCH_BUSY) begin
            addr_off = (cnt_q > 3'd3) ? 32'd3 : 32'(cnt_q);
        end
        bus.mem_addr = pc_q + addr_off;
    end

    assign bus.instr_valid = (state_q == FETCH_VALID);
    assign bus.instr       = lanes_q;
    assign bus.instr_pc    = pc_q;
    assign bus.busy        = (state_q == FETCH_BUSY);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte memory model with registered read, a
// scoreboard of expected {instr, instr_pc} checked at every decoder accept.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [7:0]  mem [0:1023];
    logic [63:0] exp_q [$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: 1 KB, aliased on addr[9:0], one cycle read latency.
    always @(posedge clk) bus.mem_data <= {24'h0, mem[bus.mem_addr[9:0]]};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        a1 = a + 32'd1;
        a2 = a + 32'd2;
        a3 = a + 32'd3;
        return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check_eq("rst_instr", bus.instr, 32'h0);
        check_eq("rst_instr_pc", bus.instr_pc, 32'h0);
        check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
    endtask

    // Caller sets up the edge that starts the fetch; this runs FETCH through VALID.
    task automatic expect_fetch(input logic [31:0] pc, input int drop_at);
        logic [31:0] off;
        exp_q.push_back({word_at(pc), pc});
        for (int c = 0; c <= 4; c++) begin
            step();
            if (c == 0) begin
                bus.redirect_valid = 1'b0;
                bus.instr_ready    = 1'b0;
                check_eq("valid_low_in_fetch", {31'h0, bus.instr_valid}, 32'h0);
            end
            off = (c > 3) ? 32'd3 : 32'(c);
            check_eq("fetch_mem_addr", bus.mem_addr, pc + off);
            check_eq("fetch_busy", {31'h0, bus.busy}, 32'h1);
            if (c == drop_at) bus.enable = 1'b0;
        end
        step();
        check_eq("valid_after_5", {31'h0, bus.instr_valid}, 32'h1);
        check_eq("valid_busy_low", {31'h0, bus.busy}, 32'h0);
        check_eq("valid_instr_pc", bus.instr_pc, pc);
    endtask

    // Scoreboard: each accept must match the oldest outstanding fetch.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {31'h0, bus.instr_valid}, 32'h0);
            end else if (bus.instr_ready) begin
                e = exp_q.pop_front();
                check_eq("sb_instr", bus.instr, e[63:32]);
                check_eq("sb_instr_pc", bus.instr_pc, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;
        mem[1] = 8'h00;
        mem[2] = 8'h50;
        mem[3] = 8'h00;

        rst_n              = 1'b0;
        bus.enable         = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        check_reset_outputs();

        // First fetch from reset PC.
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        expect_fetch(32'h0, -1);
        check_eq("first_word", bus.instr, 32'h0050_0013);

        // Decoder stalls; word and PC must hold.
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("hold_valid", {31'h0, bus.instr_valid}, 32'h1);
            check_eq("hold_instr", bus.instr, 32'h0050_0013);
            check_eq("hold_pc", bus.instr_pc, 32'h0);
        end

        // Accept and continue sequentially.
        bus.instr_ready = 1'b1;
        expect_fetch(32'h4, -1);

        // Accept, then redirect at cnt=2 of the fetch from 8.
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        step();
        step();
        check_eq("pre_redirect_addr", bus.mem_addr, 32'hA);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        expect_fetch(32'h102, -1);

        // Redirect coincident with accept.
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        expect_fetch(32'h40, -1);

        // Enable dropped mid-fetch: word still completes.
        bus.instr_ready = 1'b1;
        expect_fetch(32'h44, 2);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check_eq("idle_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("idle_valid", {31'h0, bus.instr_valid}, 32'h0);
        check_eq("idle_mem_addr", bus.mem_addr, 32'h48);
        step();
        check_eq("idle_hold_addr", bus.mem_addr, 32'h48);
        check_eq("idle_hold_busy", {31'h0, bus.busy}, 32'h0);
        bus.enable = 1'b1;
        expect_fetch(32'h48, -1);

        // Fetch across the 2^32 wrap.
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        expect_fetch(32'hFFFF_FFFE, -1);
        bus.instr_ready = 1'b1;
        bus.enable      = 1'b0;
        step();
        bus.instr_ready = 1'b0;
        check_eq("wrap_pc", bus.instr_pc, 32'h2);
        check_eq("wrap_idle_addr", bus.mem_addr, 32'h2);
        check_eq("wrap_idle_busy", {31'h0, bus.busy}, 32'h0);

        // Reset in the middle of a fetch.
        bus.enable = 1'b1;
        step();
        step();
        step();
        check_eq("mid_fetch_busy", {31'h0, bus.busy}, 32'h1);
        check_eq("mid_fetch_addr", bus.mem_addr, 32'h4);
        rst_n = 1'b0;
        step();
        check_reset_outputs();
        rst_n      = 1'b1;
        bus.enable = 1'b0;
        step();
        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
